// File: rtl/multi_clock_divider.sv
// Multi-channel programmable clock divider with glitch-free limit updates and a shared sync strobe.
// Optional feature: define MCD_TICK_OUT_EN to add the per-channel tick output.
module multi_clock_divider #(
    parameter int NUM_CH      = 2,
    parameter int COUNT_WIDTH = 24,
    parameter int DEFAULT_MAX = 6000000 - 1,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      en,
    input  logic                   sync,
    input  logic                   cfg_valid,
    input  logic [CH_W-1:0]        cfg_ch,
    input  logic [COUNT_WIDTH-1:0] cfg_max,
    output logic                   cfg_ready,
    output logic [NUM_CH-1:0]      out
`ifdef MCD_TICK_OUT_EN
    ,
    output logic [NUM_CH-1:0]      tick
`endif
);

    logic [COUNT_WIDTH-1:0] cnt      [NUM_CH];
    logic [COUNT_WIDTH-1:0] lim      [NUM_CH];
    logic [COUNT_WIDTH-1:0] pend_val [NUM_CH];
    logic [NUM_CH-1:0]      pend;
    logic [NUM_CH-1:0]      wrap;
    logic [NUM_CH-1:0]      apply;
    logic [NUM_CH-1:0]      wr;

    // Indices with no channel behind them stay ready so such writes are swallowed.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
        end
    end

    // A write is only accepted while its channel has nothing pending, so wr and apply never overlap.
    always_comb begin
        wrap  = '0;
        apply = '0;
        wr    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wrap[i]  = en[i] && (cnt[i] == lim[i]) && !sync;
            apply[i] = pend[i] && (sync || !en[i] || wrap[i]);
            wr[i]    = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out  <= '0;
            pend <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt[i]      <= '0;
                lim[i]      <= COUNT_WIDTH'(DEFAULT_MAX);
                pend_val[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (sync) begin
                    cnt[i] <= '0;
                    out[i] <= 1'b0;
                end else if (wrap[i]) begin
                    cnt[i] <= '0;
                    out[i] <= ~out[i];
                end else if (en[i]) begin
                    cnt[i] <= cnt[i] + COUNT_WIDTH'(1);
                end

                if (apply[i]) begin
                    lim[i]  <= pend_val[i];
                    pend[i] <= 1'b0;
                end else if (wr[i]) begin
                    pend_val[i] <= cfg_max;
                    pend[i]     <= 1'b1;
                end
            end
        end
    end

`ifdef MCD_TICK_OUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick <= '0;
        else     tick <= wrap;
    end
`endif

endmodule
